// File: rtl/lockstep_checker_pkg.sv
// Shared types and helpers for the lockstep output checker.
//   state_t : sweep controller states (IDLE, RUN, DRAIN, DONE)
//   sat_inc : increment that holds at a caller-supplied ceiling
package lockstep_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-latency delay line carrying the {valid, index} tag of each stimulus
// vector so it arrives at the comparator together with the module outputs.
//   clk, rst : clock and synchronous active-high reset (clears every stage)
//   d_i      : tag entering the line
//   q_o      : tag delayed by DEPTH cycles (DEPTH = 0 is a plain wire)
module tag_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= d_i;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign q_o = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lockstep_output_checker.sv
// Exhaustive lockstep equivalence checker. Sweeps every IN_WIDTH-bit vector
// into a module under test and a ground-truth module, compares their outputs
// PIPELINE_DEPTH cycles later under a mask, and records the verdict.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a sweep (honoured in IDLE or DONE only)
//   cmp_mask          : per-bit compare enable, sampled on each compare cycle
//   out_test, out_gt  : outputs of the module under test / ground truth
//   stim, stim_valid  : stimulus vector driven to both modules
//   busy, done, pass  : sweep status; pass = done with zero mismatches
//   mismatch_count    : saturating count of mismatching vectors
//   first_fail_*      : index and raw outputs of the first mismatch
module lockstep_output_checker
    import lockstep_checker_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 2,
    parameter int unsigned OUT_WIDTH      = 1,
    parameter int unsigned PIPELINE_DEPTH = 2,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OUT_WIDTH-1:0] cmp_mask,
    input  logic [OUT_WIDTH-1:0] out_test,
    input  logic [OUT_WIDTH-1:0] out_gt,
    output logic [IN_WIDTH-1:0]  stim,
    output logic                 stim_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_WIDTH-1:0] mismatch_count,
    output logic [IN_WIDTH-1:0]  first_fail_stim,
    output logic [OUT_WIDTH-1:0] first_fail_test,
    output logic [OUT_WIDTH-1:0] first_fail_gt,
    output logic                 first_fail_valid
);

    localparam int unsigned TAG_W   = IN_WIDTH + 1;
    localparam int unsigned DRAIN_W = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((PIPELINE_DEPTH > 0) ? PIPELINE_DEPTH - 1 : 0);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    state_t               state_q;
    logic [IN_WIDTH-1:0]  stim_q;
    logic                 stim_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]  ff_stim_q, ff_stim_d;
    logic [OUT_WIDTH-1:0] ff_test_q, ff_test_d;
    logic [OUT_WIDTH-1:0] ff_gt_q, ff_gt_d;
    logic                 ff_valid_q, ff_valid_d;

    logic [TAG_W-1:0]     tag_in;
    logic [TAG_W-1:0]     tag_out;
    logic                 cmp_valid;
    logic [IN_WIDTH-1:0]  cmp_idx;
    logic                 mismatch;

    // The tag travels with the vector so the comparator knows which index the
    // returning outputs belong to without any latency arithmetic of its own.
    assign tag_in = {stim_valid_q, stim_q};

    tag_delay_line #(
        .DEPTH (PIPELINE_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk (clk),
        .rst (rst),
        .d_i (tag_in),
        .q_o (tag_out)
    );

    assign cmp_valid = tag_out[TAG_W-1];
    assign cmp_idx   = tag_out[IN_WIDTH-1:0];
    assign mismatch  = cmp_valid && (((out_test ^ out_gt) & cmp_mask) != '0);

    always_comb begin
        cnt_d      = cnt_q;
        ff_stim_d  = ff_stim_q;
        ff_test_d  = ff_test_q;
        ff_gt_d    = ff_gt_q;
        ff_valid_d = ff_valid_q;
        if (mismatch) begin
            cnt_d = CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_MAX));
            if (!ff_valid_q) begin
                ff_stim_d  = cmp_idx;
                ff_test_d  = out_test;
                ff_gt_d    = out_gt;
                ff_valid_d = 1'b1;
            end
        end
    end

    // pass is loaded from cnt_d on the DONE transition because the last
    // compare lands in the same cycle the controller leaves RUN/DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stim_q       <= '0;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            drain_q      <= '0;
            cnt_q        <= '0;
            ff_stim_q    <= '0;
            ff_test_q    <= '0;
            ff_gt_q      <= '0;
            ff_valid_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ff_stim_q  <= ff_stim_d;
            ff_test_q  <= ff_test_d;
            ff_gt_q    <= ff_gt_d;
            ff_valid_q <= ff_valid_d;

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        stim_q       <= '0;
                        stim_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        cnt_q        <= '0;
                        ff_stim_q    <= '0;
                        ff_test_q    <= '0;
                        ff_gt_q      <= '0;
                        ff_valid_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (stim_q == '1) begin
                        stim_q       <= '0;
                        stim_valid_q <= 1'b0;
                        if (PIPELINE_DEPTH == 0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (cnt_d == '0);
                        end else begin
                            state_q <= DRAIN;
                            drain_q <= DRAIN_LAST;
                        end
                    end else begin
                        stim_q <= stim_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (cnt_d == '0);
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim             = stim_q;
    assign stim_valid       = stim_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_count   = cnt_q;
    assign first_fail_stim  = ff_stim_q;
    assign first_fail_test  = ff_test_q;
    assign first_fail_gt    = ff_gt_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_lockstep_output_checker.sv
// Bench for lockstep_output_checker. Instance A: IN=2, OUT=2, D=2, CNT=16 with
// two-stage registered emulated modules. Instance B: IN=3, OUT=1, D=0, CNT=2
// with combinational emulated modules. A sweep-level model predicts every
// output on every cycle; literal checks pin the model to hand-derived values.
module tb_lockstep_output_checker;

    localparam int NA = 4, DA = 2, MAXA = 65535;
    localparam int NB = 8, DB = 0, MAXB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [1:0] mask_a = 2'b11;
    logic       mask_b = 1'b1;
    int mode_a = 0, mode_b = 0;

    logic [1:0]  out_test_a, out_gt_a, t1_a, t2_a, g1_a, g2_a;
    logic        out_test_b, out_gt_b;
    logic [1:0]  stim_a, ffs_a;
    logic [2:0]  stim_b, ffs_b;
    logic        sv_a, busy_a, done_a, pass_a, ffv_a;
    logic        sv_b, busy_b, done_b, pass_b, ffv_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [1:0]  fft_a, ffg_a;
    logic        fft_b, ffg_b;

    int total = 0, bad = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    lockstep_output_checker #(
        .IN_WIDTH(2), .OUT_WIDTH(2), .PIPELINE_DEPTH(2), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cmp_mask(mask_a),
        .out_test(out_test_a), .out_gt(out_gt_a),
        .stim(stim_a), .stim_valid(sv_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_count(cnt_a), .first_fail_stim(ffs_a),
        .first_fail_test(fft_a), .first_fail_gt(ffg_a), .first_fail_valid(ffv_a)
    );

    lockstep_output_checker #(
        .IN_WIDTH(3), .OUT_WIDTH(1), .PIPELINE_DEPTH(0), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cmp_mask(mask_b),
        .out_test(out_test_b), .out_gt(out_gt_b),
        .stim(stim_b), .stim_valid(sv_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_count(cnt_b), .first_fail_stim(ffs_b),
        .first_fail_test(fft_b), .first_fail_gt(ffg_b), .first_fail_valid(ffv_b)
    );

    // Emulated modules. A: bit0 per test plan, bit1 = a^b (inverted in mode 2).
    function automatic logic [1:0] fa_test(input int i, input int md);
        logic [1:0] v; logic a, b;
        v = 2'(i); a = v[0]; b = v[1];
        case (md)
            1:       return {a ^ b, a | b};
            2:       return {~(a ^ b), a & b};
            default: return {a ^ b, a & b};
        endcase
    endfunction
    function automatic logic [1:0] fa_gt(input int i, input int md);
        logic [1:0] v; logic a, b;
        v = 2'(i); a = v[0]; b = v[1];
        if (md == 0) return {a ^ b, ~(~a | ~b)};
        return {a ^ b, a & b};
    endfunction
    function automatic logic fb_test(input int i, input int md);
        logic [2:0] v;
        v = 3'(i);
        if (md == 0) return ^v;
        return (i == 3) || (i == 5);
    endfunction
    function automatic logic fb_gt(input int i, input int md);
        logic [2:0] v;
        v = 3'(i);
        if (md == 0) return ~(^v);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        t1_a <= fa_test(int'(stim_a), mode_a); t2_a <= t1_a;
        g1_a <= fa_gt(int'(stim_a), mode_a);   g2_a <= g1_a;
    end
    assign out_test_a = t2_a;
    assign out_gt_a   = g2_a;
    assign out_test_b = fb_test(int'(stim_b), mode_b);
    assign out_gt_b   = fb_gt(int'(stim_b), mode_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Sweep-level model: which sweep is live and how many edges since its start.
    bit act_a = 0, act_b = 0;
    int age_a = 0, age_b = 0, md_a = 0, md_b = 0;
    logic [1:0] mk_a = '0;
    logic mk_b = 1'b0;

    always @(posedge clk) begin
        if (rst) act_a = 0;
        else if (start_a && (!act_a || age_a >= NA + DA)) begin
            act_a = 1; age_a = 0; md_a = mode_a; mk_a = mask_a;
        end else if (act_a) age_a++;
        if (rst) act_b = 0;
        else if (start_b && (!act_b || age_b >= NB + DB)) begin
            act_b = 1; age_b = 0; md_b = mode_b; mk_b = mask_b;
        end else if (act_b) age_b++;
    end

    // Vectors whose compare result is already registered at this sample.
    function automatic int seen_cnt(input int age, input int d, input int n);
        int s;
        s = age - d;
        if (s < 0) s = 0;
        if (s > n) s = n;
        return s;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int s, c, f;
            logic [7:0] dif;
            // instance A
            dif = '0;
            for (int i = 0; i < NA; i++) dif[i] = |((fa_test(i, md_a) ^ fa_gt(i, md_a)) & mk_a);
            s = act_a ? seen_cnt(age_a, DA, NA) : 0;
            c = 0; f = -1;
            for (int i = 0; i < s; i++) if (dif[i]) begin
                if (c < MAXA) c++;
                if (f < 0) f = i;
            end
            check("A.stim_valid", 32'(sv_a), 32'(act_a && age_a < NA));
            check("A.stim", 32'(stim_a), (act_a && age_a < NA) ? 32'(age_a) : 32'd0);
            check("A.busy", 32'(busy_a), 32'(act_a && age_a < NA + DA));
            check("A.done", 32'(done_a), 32'(act_a && age_a >= NA + DA));
            check("A.pass", 32'(pass_a), 32'(act_a && age_a >= NA + DA && c == 0));
            check("A.count", 32'(cnt_a), 32'(c));
            check("A.ff_valid", 32'(ffv_a), 32'(f >= 0));
            check("A.ff_stim", 32'(ffs_a), (f >= 0) ? 32'(f) : 32'd0);
            check("A.ff_test", 32'(fft_a), (f >= 0) ? 32'(fa_test(f, md_a)) : 32'd0);
            check("A.ff_gt", 32'(ffg_a), (f >= 0) ? 32'(fa_gt(f, md_a)) : 32'd0);
            // instance B
            dif = '0;
            for (int i = 0; i < NB; i++) dif[i] = (fb_test(i, md_b) ^ fb_gt(i, md_b)) & mk_b;
            s = act_b ? seen_cnt(age_b, DB, NB) : 0;
            c = 0; f = -1;
            for (int i = 0; i < s; i++) if (dif[i]) begin
                if (c < MAXB) c++;
                if (f < 0) f = i;
            end
            check("B.stim_valid", 32'(sv_b), 32'(act_b && age_b < NB));
            check("B.stim", 32'(stim_b), (act_b && age_b < NB) ? 32'(age_b) : 32'd0);
            check("B.busy", 32'(busy_b), 32'(act_b && age_b < NB + DB));
            check("B.done", 32'(done_b), 32'(act_b && age_b >= NB + DB));
            check("B.pass", 32'(pass_b), 32'(act_b && age_b >= NB + DB && c == 0));
            check("B.count", 32'(cnt_b), 32'(c));
            check("B.ff_valid", 32'(ffv_b), 32'(f >= 0));
            check("B.ff_stim", 32'(ffs_b), (f >= 0) ? 32'(f) : 32'd0);
            check("B.ff_test", 32'(fft_b), (f >= 0) ? 32'(fb_test(f, md_b)) : 32'd0);
            check("B.ff_gt", 32'(ffg_b), (f >= 0) ? 32'(fb_gt(f, md_b)) : 32'd0);
        end
    end

    // Start a sweep on A, optionally poke start again at sample 'poke', and
    // return the number of samples from the start edge until done is seen.
    task automatic sweep_a(input int md, input logic [1:0] mk, input int poke, output int lat);
        mode_a = md; mask_a = mk; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_a) begin lat = n; break; end
            start_a = (n == poke);
        end
        start_a = 1'b0;
        if (lat == 0) check("A.done_timeout", 32'(done_a), 32'd1);
    endtask

    task automatic wait_done_b(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_b) begin lat = n; break; end
        end
        if (lat == 0) check("B.done_timeout", 32'(done_b), 32'd1);
    endtask

    initial begin
        int lat;
        @(posedge clk); #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.A.done", 32'(done_a), 32'd0);
        check("reset.A.count", 32'(cnt_a), 32'd0);
        check("reset.B.stim_valid", 32'(sv_b), 32'd0);

        // A: equivalent modules
        sweep_a(0, 2'b11, 0, lat);
        check("A1.latency", 32'(lat), 32'd7);
        check("A1.pass", 32'(pass_a), 32'd1);
        check("A1.count", 32'(cnt_a), 32'd0);

        // A: test = a|b
        sweep_a(1, 2'b11, 0, lat);
        check("A2.count", 32'(cnt_a), 32'd2);
        check("A2.ff_stim", 32'(ffs_a), 32'd1);
        check("A2.ff_test0", 32'(fft_a[0]), 32'd1);
        check("A2.ff_gt0", 32'(ffg_a[0]), 32'd0);
        check("A2.pass", 32'(pass_a), 32'd0);

        // A: bit1 inverted, masked off then compared
        sweep_a(2, 2'b01, 0, lat);
        check("A3.pass", 32'(pass_a), 32'd1);
        sweep_a(2, 2'b11, 0, lat);
        check("A4.count", 32'(cnt_a), 32'd4);
        check("A4.ff_stim", 32'(ffs_a), 32'd0);

        // A: all-zero mask hides every difference
        sweep_a(1, 2'b00, 0, lat);
        check("A5.pass", 32'(pass_a), 32'd1);
        check("A5.ff_valid", 32'(ffv_a), 32'd0);

        // A: reset in RUN cycle 2, then a clean sweep with a start poke in RUN
        mode_a = 0; mask_a = 2'b11; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("A6.busy", 32'(busy_a), 32'd0);
        check("A6.stim_valid", 32'(sv_a), 32'd0);
        check("A6.ff_valid", 32'(ffv_a), 32'd0);
        sweep_a(0, 2'b11, 2, lat);
        check("A7.latency", 32'(lat), 32'd7);
        check("A7.pass", 32'(pass_a), 32'd1);

        // B: XOR vs XNOR, combinational, counter saturates
        mode_b = 0; start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        wait_done_b(lat);
        check("B1.latency", 32'(lat), 32'd9);
        check("B1.count", 32'(cnt_b), 32'd3);
        check("B1.ff_stim", 32'(ffs_b), 32'd0);
        check("B1.pass", 32'(pass_b), 32'd0);

        // B: start held high through a sweep and into DONE restarts at once
        mode_b = 1; start_b = 1'b1;
        @(posedge clk); #1;
        wait_done_b(lat);
        check("B2.latency", 32'(lat), 32'd9);
        check("B2.count", 32'(cnt_b), 32'd2);
        @(posedge clk); #1 start_b = 1'b0;
        wait_done_b(lat);
        check("B3.latency", 32'(lat), 32'd9);
        check("B3.ff_stim", 32'(ffs_b), 32'd3);
        check("B3.count", 32'(cnt_b), 32'd2);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
